icache_miss_ctrl: RTL
=====================

# icache_miss_ctrl

- Read-only miss handler between the fetch stage and the direct-mapped `cache` array.
- Checks each fetch address against the cache; on a hit, returns data one cycle later.
- On a miss, fetches the word from memory over a valid/ready request channel, writes it into the cache, then returns it.
- Invalidates every cache line after reset and on an explicit flush request, since the cache lines have no reset of their own.

## Interface
Parameters:
- NUM_CACHE_LINES, 4, line count of the attached cache; power of two, ≥2. SetBits = $clog2(NUM_CACHE_LINES).
- ADDR_WIDTH, XLEN, width of the fetch address (equals the cache `inp` width).
- DATA_WIDTH, XLEN, word width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  fetch request.
- req_addr  in  ADDR_WIDTH  fetch address.
- req_ready  out  1  combinational: state==IDLE && !flush_req && !flush_pend.
- resp_valid  out  1  registered one-cycle pulse; no back-pressure.
- resp_data  out  DATA_WIDTH  registered fetched word.
- flush_req  in  1  request to invalidate all lines.
- flush_done  out  1  registered one-cycle pulse at the end of any sweep.
- cache_rw  out  1  cache write enable.
- cache_addr  out  ADDR_WIDTH  cache `inp`.
- cache_wdata  out  DATA_WIDTH  cache `data_in`.
- cache_valid  out  1  cache `valid_in`.
- cache_hit  in  1  cache `hit`.
- cache_rdata  in  DATA_WIDTH  cache `data_out`.
- mem_req_valid  out  1  memory read request.
- mem_req_addr  out  ADDR_WIDTH  memory read address.
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  memory read data valid.
- mem_resp_data  in  DATA_WIDTH  memory read data.

## Operation
States: FLUSH, IDLE, MEM_REQ, MEM_WAIT, FILL.

Registers: miss_addr, fill_data, flush_cnt[SetBits-1:0], flush_pend.

- **Reset (rst_n low at an edge):**
  - state=FLUSH, flush_cnt=0, flush_pend=0.
  - resp_valid, resp_data, flush_done and mem_req_valid read 0 after that edge.
  - A miss in progress is abandoned.
- **FLUSH:**
  - Drives cache_rw=1, cache_valid=0, cache_addr={zeros, flush_cnt}, cache_wdata=0.
  - flush_cnt increments each cycle.
  - In the cycle where flush_cnt==NUM_CACHE_LINES-1: next state IDLE, flush_cnt wraps to 0, flush_done=1 in the following cycle.
  - Sweep length is exactly NUM_CACHE_LINES cycles.
- **IDLE:**
  - cache_addr=req_addr, cache_rw=0.
  - If flush_req or flush_pend: go to FLUSH and clear flush_pend; any request is not accepted.
  - Else if req_valid && cache_hit: next cycle resp_valid=1, resp_data=cache_rdata; stay in IDLE.
  - Else if req_valid && !cache_hit: miss_addr←req_addr, go to MEM_REQ.
- **MEM_REQ:**
  - mem_req_valid=1, mem_req_addr=miss_addr; held stable until mem_req_ready.
  - Go to MEM_WAIT in the cycle mem_req_valid && mem_req_ready.
- **MEM_WAIT:**
  - On mem_resp_valid: fill_data←mem_resp_data, go to FILL.
  - mem_resp_valid in any other state is ignored.
- **FILL:**
  - One cycle: cache_rw=1, cache_valid=1, cache_addr=miss_addr, cache_wdata=fill_data.
  - Next cycle: resp_valid=1, resp_data=fill_data, state IDLE.
- **flush_req outside IDLE:**
  - Sets flush_pend; the sweep runs immediately after returning to IDLE.
  - A miss is never interrupted by a flush.
- **Defaults:** cache_rw=0 and cache_valid=0 whenever not in FLUSH or FILL.

## Timing
- **Hit:** accepted at cycle T, resp_valid at T+1.
  - Back-to-back hits sustain 1 response per cycle.
- **Miss, zero memory stall:**
  - Accepted T; MEM_REQ T+1 (accepted); MEM_WAIT T+2 (resp); FILL T+3; resp_valid T+4.
  - Each memory wait cycle adds 1.
- **Memory contract:** the response arrives ≥1 cycle after request acceptance; one request is outstanding at most.
- **After reset release:**
  - req_ready=0 for NUM_CACHE_LINES cycles.
  - flush_done pulses in the cycle req_ready first rises.
- **Reset mid-miss:** the memory side must be reset together with this block; stale responses after reset are not guarded.

## Test plan
- **Reset sweep:**
  - Stimulus: rst_n low 2 cycles, then high, NUM_CACHE_LINES=4.
  - Required: cache_rw=1, cache_valid=0 with cache_addr set bits 0,1,2,3 on 4 consecutive cycles; flush_done pulse on the 5th; req_ready=1 from the 5th.
- **Cold miss:**
  - Stimulus: req_addr=0x0000_0104, memory ready immediately, responds 0xDEADBEEF 1 cycle after accept.
  - Required: mem_req_addr=0x104; FILL writes 0xDEADBEEF to 0x104; resp_valid with 0xDEADBEEF 4 cycles after accept.
- **Hit after fill:**
  - Stimulus: re-request 0x104 on three consecutive cycles.
  - Required: three consecutive resp_valid pulses, each 0xDEADBEEF; mem_req_valid stays 0.
- **Memory back-pressure:**
  - Stimulus: mem_req_ready low for 3 cycles, then a 5-cycle response delay.
  - Required: mem_req_valid and mem_req_addr stable throughout; resp_valid 11 cycles after accept; req_ready=0 until then.
- **Flush during miss:**
  - Stimulus: assert flush_req in MEM_WAIT.
  - Required: miss completes with correct resp_data; FLUSH starts the cycle after returning to IDLE; a subsequent request to the same address misses again.
- **Reset mid-miss:**
  - Stimulus: rst_n low while in MEM_REQ.
  - Required: mem_req_valid=0 after that edge; sweep restarts from flush_cnt=0; resp_valid never asserted for the abandoned request.

Source files
------------

// File: rtl/icache_miss_ctrl_if.sv
// icache_miss_ctrl_if: fetch, flush, cache-array and memory-channel signals of the miss handler
interface icache_miss_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_ready;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  flush_req;
  logic                  flush_done;
  logic                  cache_rw;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [DATA_WIDTH-1:0] cache_wdata;
  logic                  cache_valid;
  logic                  cache_hit;
  logic [DATA_WIDTH-1:0] cache_rdata;
  logic                  mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;
  modport slave (
    input  req_valid, req_addr, flush_req, cache_hit, cache_rdata,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, flush_done, cache_rw, cache_addr,
           cache_wdata, cache_valid, mem_req_valid, mem_req_addr
  );
  modport master (
    output req_valid, req_addr, flush_req, cache_hit, cache_rdata,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, flush_done, cache_rw, cache_addr,
           cache_wdata, cache_valid, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_miss_ctrl.sv
// icache_miss_ctrl: read-only miss handler for a direct-mapped icache; sweeps all lines invalid after reset or flush
module icache_miss_ctrl #(
  parameter int NUM_CACHE_LINES = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input logic               clk,
  input logic               rst_n,
  icache_miss_ctrl_if.slave bus
);
  localparam int SB = $clog2(NUM_CACHE_LINES);
  localparam logic [SB-1:0] LAST = SB'(NUM_CACHE_LINES - 1);
  typedef enum logic [2:0] {FLUSH, IDLE, MEM_REQ, MEM_WAIT, FILL} state_t;
  state_t state, state_nx;
  logic [SB-1:0] flush_cnt;
  logic flush_pend;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic hit, miss;
  always_comb begin
    bus.req_ready     = state == IDLE && !bus.flush_req && !flush_pend;
    hit               = bus.req_ready && bus.req_valid && bus.cache_hit;
    miss              = bus.req_ready && bus.req_valid && !bus.cache_hit;
    bus.cache_rw      = state == FLUSH || state == FILL;
    bus.cache_valid   = state == FILL;
    bus.cache_addr    = state == FLUSH ? ADDR_WIDTH'(flush_cnt) : state == FILL ? miss_addr : bus.req_addr;
    bus.cache_wdata   = state == FILL ? fill_data : '0;
    bus.mem_req_valid = state == MEM_REQ;
    bus.mem_req_addr  = miss_addr;
    state_nx          = state;
    unique case (state)
      FLUSH:    state_nx = flush_cnt == LAST ? IDLE : FLUSH;
      IDLE:     state_nx = (bus.flush_req || flush_pend) ? FLUSH : miss ? MEM_REQ : IDLE;
      MEM_REQ:  state_nx = bus.mem_req_ready ? MEM_WAIT : MEM_REQ;
      MEM_WAIT: state_nx = bus.mem_resp_valid ? FILL : MEM_WAIT;
      FILL:     state_nx = IDLE;
      default:  state_nx = FLUSH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= FLUSH;
      flush_cnt      <= '0;
      flush_pend     <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.flush_done <= 1'b0;
    end else begin
      state          <= state_nx;
      flush_cnt      <= state == FLUSH ? flush_cnt + 1'b1 : '0;
      flush_pend     <= state == IDLE ? 1'b0 : flush_pend | bus.flush_req;
      bus.flush_done <= state == FLUSH && flush_cnt == LAST;
      bus.resp_valid <= hit || state == FILL;
      bus.resp_data  <= state == FILL ? fill_data : hit ? bus.cache_rdata : bus.resp_data;
    end
  end
  // Data-path registers need no reset: they are always written before being used.
  always_ff @(posedge clk) begin
    miss_addr <= miss ? bus.req_addr : miss_addr;
    fill_data <= (state == MEM_WAIT && bus.mem_resp_valid) ? bus.mem_resp_data : fill_data;
  end
endmodule
